spi_resp_perifericos: RTL and testbench
=======================================

# spi_resp_perifericos

SPI responder (slave) matching the team's SPI peripheral master: it receives an 8-bit command on MOSI and returns a 16-bit response on MISO within one SS-framed, 24-bit transaction. SPI mode 0 (CPOL=0, CPHA=0), MSB first. All SPI pins are oversampled and synchronized into the single system clock. The block sits on the peripheral side, between the SPI pins and a local register/data source that supplies the response word.

## Interface
- CMD_W, 8, command bits received per frame
- RESP_W, 16, response bits transmitted per frame
- SYNC_STAGES, 2, synchronizer flops on SCK, SS and MOSI (≥2)

- spi_clk_i  in  1  system clock; all logic on rising edge
- spi_rst_i  in  1  reset, asynchronous assert, active-low
- SCK_SPI  in  1  SPI serial clock from master, idle low
- SS  in  1  slave select, active-low
- MOSI  in  1  master-out data
- MISO  out  1  slave-out data
- miso_oe_o  out  1  MISO output enable; pad drives MISO only while high
- tx_data_i  in  RESP_W  response word, captured at frame start
- rx_cmd_o  out  CMD_W  last complete command received
- cmd_valid_o  out  1  one-cycle pulse when rx_cmd_o updates
- busy_o  out  1  high while a frame is in progress
- done_o  out  1  one-cycle pulse: frame closed after exactly CMD_W+RESP_W bits
- err_o  out  1  one-cycle pulse: frame closed with the wrong bit count

## Operation
- SCK_SPI, SS and MOSI each pass through SYNC_STAGES flops, then one edge-detect register. Rise/fall/select events are derived from the synchronized copies only.
- States: IDLE, CMD, RESP, HOLD.
- IDLE: wait for synchronized SS falling.
  - On SS falling: capture tx_data_i into the response shift register, clear the bit counter, set busy_o and miso_oe_o, set MISO=0, go to CMD.
- CMD: each SCK rise shifts synchronized MOSI into the command shift register (LSB in) and increments the counter.
  - On the CMD_W-th rise: load rx_cmd_o, pulse cmd_valid_o, go to RESP.
  - SCK falls are ignored; MISO stays 0.
- RESP:
  - On the first SCK fall in RESP: drive MISO = resp[RESP_W-1].
  - On each subsequent fall: shift left and drive the next bit.
  - SCK rises increment the counter.
  - On rise number CMD_W+RESP_W, go to HOLD.
- HOLD: MISO holds the last bit. Any further SCK rise sets an internal overrun flag; further edges have no other effect.
- SS rising in any non-IDLE state:
  - Clear busy_o and miso_oe_o; set MISO=0; go to IDLE.
  - Pulse done_o if the state was HOLD and no overrun occurred; otherwise pulse err_o.
  - An SS rise in CMD never pulses cmd_valid_o, and rx_cmd_o keeps its previous value.
- The counter is CMD_W+RESP_W+1 wide enough and saturates at CMD_W+RESP_W; it never wraps.
- Simultaneous SS rise and SCK edge in the same cycle: SS takes priority and the SCK edge is discarded.
- Reset (including mid-frame): all state is cleared immediately. After release, the block waits in IDLE for a fresh SS falling edge. An SS that is already low at release does not start a frame.

## Timing
- Reset values: MISO=0, miso_oe_o=0, rx_cmd_o=0, cmd_valid_o=0, busy_o=0, done_o=0, err_o=0. Internal shift registers and counter are 0; state is IDLE.
- Pin-to-event latency is SYNC_STAGES+1 cycles (3 at default). MOSI is delayed identically, so it is sampled aligned with its SCK rise.
- busy_o/miso_oe_o go high 3 cycles after SS pin falls. tx_data_i must be stable during that cycle.
- cmd_valid_o pulses 3 cycles after the 8th SCK pin rise.
- MISO changes 4 cycles after each SCK pin fall (event cycle plus output register).
- Requirement on the master: SCK high and low phases each ≥ SYNC_STAGES+3 spi_clk_i cycles. SS setup to first SCK rise and hold after last SCK fall ≥ the same.
- done_o/err_o pulse 4 cycles after the SS pin rises. The next frame may start on the cycle after that pulse.

## Test plan
- Master sends cmd 0xA8 with tx_data_i=0x1234 over 24 SCK, then raises SS -> rx_cmd_o=0xA8 with one cmd_valid_o pulse; bits read on MISO at SCK rises 9..24 = 0x1234; exactly one done_o; err_o never high.
- Patterns 0xFF/0x0000 then 0x00/0xFFFF, back-to-back with minimum SS gap -> both commands and responses exact; two done_o pulses; busy_o low between frames.
- SS raised after 5 SCK rises -> err_o pulse, no cmd_valid_o, rx_cmd_o unchanged, MISO=0, miso_oe_o=0.
- Frame with 25 SCK rises, cmd 0x3C, tx_data_i=0xBEEF -> rx_cmd_o=0x3C, MISO stream 0xBEEF, err_o pulse on SS rise, no done_o.
- spi_rst_i pulled low at SCK rise 12 with SS held low, then released -> all outputs at reset values; no frame starts until SS toggles high then low; the next full frame with 0x5A/0xA5A5 completes correctly.
- tx_data_i changed from 0x1111 to 0x2222 during CMD phase -> MISO returns 0x1111, the value captured at SS assertion.

Source files
------------

// File: rtl/spi_resp_perifericos.sv
// SPI mode-0 responder: 8-bit command in on MOSI, 16-bit response out on MISO,
// one SS-framed 24-bit transaction, all pins oversampled on spi_clk_i.
// Ports:
//   spi_clk_i, spi_rst_i     system clock, async active-low reset
//   SCK_SPI, SS, MOSI        raw SPI pins from the master
//   MISO, miso_oe_o          slave data out and its pad enable
//   tx_data_i                response word, captured at frame start
//   rx_cmd_o, cmd_valid_o    last full command and its update pulse
//   busy_o, done_o, err_o    frame in progress / good close / bad close
module spi_resp_perifericos #(
  parameter int CMD_W       = 8,
  parameter int RESP_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              spi_clk_i,
  input  logic              spi_rst_i,
  input  logic              SCK_SPI,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe_o,
  input  logic [RESP_W-1:0] tx_data_i,
  output logic [CMD_W-1:0]  rx_cmd_o,
  output logic              cmd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int TOT = CMD_W + RESP_W;
  localparam int CW  = $clog2(TOT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RESP,
    HOLD
  } state_t;

  state_t state_q;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   ss_prev_q;

  logic [CMD_W-1:0]  cmd_sh_q;
  logic [RESP_W-1:0] resp_sh_q;
  logic [CW-1:0]     cnt_q;
  logic              first_q;
  logic              ovr_q;
  logic              miso_bit_q;
  logic              miso_q;
  logic              oe_q;
  logic [CMD_W-1:0]  rx_cmd_q;
  logic              cv_q;
  logic              busy_q;
  logic              done_p_q;
  logic              err_p_q;
  logic              done_q;
  logic              err_q;

  logic sck_s;
  logic ss_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic ss_rise;
  logic ss_fall;
  logic [CW-1:0] cnt_inc;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  // Saturating bit counter increment.
  assign cnt_inc = (cnt_q == CW'(TOT)) ? cnt_q : cnt_q + CW'(1);

  // SS chain resets low so an SS already low at release is not a fall.
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      cmd_sh_q    <= '0;
      resp_sh_q   <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      ovr_q       <= 1'b0;
      miso_bit_q  <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      rx_cmd_q    <= '0;
      cv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_p_q    <= 1'b0;
      err_p_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK_SPI};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      miso_q      <= miso_bit_q;
      done_q      <= done_p_q;
      err_q       <= err_p_q;
      cv_q        <= 1'b0;
      done_p_q    <= 1'b0;
      err_p_q     <= 1'b0;
      // SS release wins over any SCK edge in the same cycle.
      if (ss_rise && state_q != IDLE) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        oe_q       <= 1'b0;
        miso_bit_q <= 1'b0;
        if (state_q == HOLD && !ovr_q) begin
          done_p_q <= 1'b1;
        end else begin
          err_p_q  <= 1'b1;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (ss_fall) begin
              resp_sh_q  <= tx_data_i;
              cnt_q      <= '0;
              ovr_q      <= 1'b0;
              busy_q     <= 1'b1;
              oe_q       <= 1'b1;
              miso_bit_q <= 1'b0;
              state_q    <= CMD;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_sh_q <= {cmd_sh_q[CMD_W-2:0], mosi_s};
              cnt_q    <= cnt_inc;
              if (cnt_q == CW'(CMD_W - 1)) begin
                rx_cmd_q <= {cmd_sh_q[CMD_W-2:0], mosi_s};
                cv_q     <= 1'b1;
                first_q  <= 1'b1;
                state_q  <= RESP;
              end
            end
          end
          RESP: begin
            // First fall presents the MSB; later falls shift then present.
            if (sck_fall) begin
              first_q <= 1'b0;
              if (first_q) begin
                miso_bit_q <= resp_sh_q[RESP_W-1];
              end else begin
                resp_sh_q  <= {resp_sh_q[RESP_W-2:0], 1'b0};
                miso_bit_q <= resp_sh_q[RESP_W-2];
              end
            end
            if (sck_rise) begin
              cnt_q <= cnt_inc;
              if (cnt_q == CW'(TOT - 1)) begin
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (sck_rise) begin
              ovr_q <= 1'b1;
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign MISO        = miso_q;
  assign miso_oe_o   = oe_q;
  assign rx_cmd_o    = rx_cmd_q;
  assign cmd_valid_o = cv_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_resp_perifericos.sv
// Directed bench for spi_resp_perifericos: drives a mode-0 SPI master
// and checks commands, MISO stream and frame-close pulses.
module tb_spi_resp_perifericos;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] tx = '0;
  logic        miso;
  logic        oe;
  logic [7:0]  rx;
  logic        cv;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cv_n = 0;
  int done_n = 0;
  int err_n = 0;
  int cv_b, done_b, err_b;

  logic [15:0] rd;
  logic        cm;

  spi_resp_perifericos dut (
    .spi_clk_i  (clk),
    .spi_rst_i  (rst_n),
    .SCK_SPI    (sck),
    .SS         (ss),
    .MOSI       (mosi),
    .MISO       (miso),
    .miso_oe_o  (oe),
    .tx_data_i  (tx),
    .rx_cmd_o   (rx),
    .cmd_valid_o(cv),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output.
  always @(negedge clk) begin
    if (cv)   cv_n   = cv_n + 1;
    if (done) done_n = done_n + 1;
    if (err)  err_n  = err_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    cv_b = cv_n;
    done_b = done_n;
    err_b = err_n;
  endtask

  // One SS-framed transfer of nrise SCK pulses; tx switches to
  // tx_mid after the third rise.
  task automatic frame(input logic [7:0] cmd,
                       input int nrise,
                       input logic [15:0] tx_mid,
                       output logic [15:0] rdv,
                       output logic cmiso);
    rdv = '0;
    cmiso = 1'b0;
    ss = 1'b0;
    for (int i = 0; i < nrise; i++) begin
      mosi = (i < 8) ? cmd[3'(7 - i)] : 1'b0;
      tick(8);
      if (i < 8) cmiso = cmiso | miso;
      else if (i < 24) rdv = {rdv[14:0], miso};
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      if (i == 2) tx = tx_mid;
    end
    mosi = 1'b0;
    tick(8);
    ss = 1'b1;
    tick(8);
  endtask

  initial begin
    tick(3);
    check("rst_miso", miso, 0);
    check("rst_oe", oe, 0);
    check("rst_rx", rx, 0);
    check("rst_cv", cv, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick(10);

    // Basic frame
    tx = 16'h1234;
    snap();
    frame(8'hA8, 24, 16'h1234, rd, cm);
    check("t1_rx", rx, 32'hA8);
    check("t1_miso_stream", rd, 32'h1234);
    check("t1_cmd_miso0", cm, 0);
    check("t1_cv", cv_n - cv_b, 1);
    check("t1_done", done_n - done_b, 1);
    check("t1_err", err_n - err_b, 0);
    check("t1_busy", busy, 0);
    check("t1_oe", oe, 0);

    // Back-to-back frames, minimum gap
    snap();
    tx = 16'h0000;
    frame(8'hFF, 24, 16'h0000, rd, cm);
    check("t2a_rx", rx, 32'hFF);
    check("t2a_stream", rd, 32'h0000);
    check("t2_gap_busy", busy, 0);
    tx = 16'hFFFF;
    frame(8'h00, 24, 16'hFFFF, rd, cm);
    check("t2b_rx", rx, 32'h00);
    check("t2b_stream", rd, 32'hFFFF);
    check("t2_done", done_n - done_b, 2);
    check("t2_err", err_n - err_b, 0);

    // Short frame: 5 rises
    snap();
    tx = 16'h5555;
    frame(8'hC3, 5, 16'h5555, rd, cm);
    check("t3_err", err_n - err_b, 1);
    check("t3_cv", cv_n - cv_b, 0);
    check("t3_done", done_n - done_b, 0);
    check("t3_rx_kept", rx, 32'h00);
    check("t3_miso", miso, 0);
    check("t3_oe", oe, 0);

    // Overrun: 25 rises
    snap();
    tx = 16'hBEEF;
    frame(8'h3C, 25, 16'hBEEF, rd, cm);
    check("t4_rx", rx, 32'h3C);
    check("t4_stream", rd, 32'hBEEF);
    check("t4_err", err_n - err_b, 1);
    check("t4_done", done_n - done_b, 0);
    check("t4_cv", cv_n - cv_b, 1);

    // Reset at SCK rise 12 with SS low
    tx = 16'h7777;
    ss = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mosi = 1'b1;
      tick(8);
      sck = 1'b1;
      tick(8);
      if (i != 11) sck = 1'b0;
    end
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    tick(2);
    check("t5_busy", busy, 0);
    check("t5_oe", oe, 0);
    check("t5_miso", miso, 0);
    check("t5_rx", rx, 0);
    check("t5_pulses", {29'd0, cv, done, err}, 0);
    sck = 1'b0;
    mosi = 1'b0;
    tick(5);
    rst_n = 1'b1;
    snap();
    tick(10);
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(8);
    end
    check("t5_no_start_busy", busy, 0);
    check("t5_no_start_oe", oe, 0);
    check("t5_no_close", (err_n - err_b) + (done_n - done_b), 0);
    ss = 1'b1;
    tick(8);
    snap();
    tx = 16'hA5A5;
    frame(8'h5A, 24, 16'hA5A5, rd, cm);
    check("t5_rx", rx, 32'h5A);
    check("t5_stream", rd, 32'hA5A5);
    check("t5_done", done_n - done_b, 1);
    check("t5_err", err_n - err_b, 0);

    // tx_data_i changes during CMD phase
    snap();
    tx = 16'h1111;
    frame(8'h81, 24, 16'h2222, rd, cm);
    check("t6_rx", rx, 32'h81);
    check("t6_stream", rd, 32'h1111);
    check("t6_done", done_n - done_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
